// File: rtl/ycbcr_to_rgb_sched.sv
// YCbCr to RGB sequencer: one signed multiplier/accumulator time-shared over R, G, B
// in a fixed six-step schedule, with a shadow/active coefficient bank and a clamped RGB output.
module ycbcr_to_rgb_sched #(
  parameter int COEF_W = 12,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        y_i,
  input  logic [7:0]        cb_i,
  input  logic [7:0]        cr_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        r_o,
  output logic [7:0]        g_o,
  output logic [7:0]        b_o,
  output logic [1:0]        chan_o,
  output logic              busy_o,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata
);

  localparam int ACC_W  = 8 + FRAC + COEF_W;
  localparam int PROD_W = COEF_W + 9;
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) << (FRAC - 1);

  typedef enum logic [2:0] {IDLE, R0, R1, G0, G1, B0, B1, OUT} state_t;

  state_t state_reg, state_next;

  logic signed [COEF_W-1:0] shadow_reg [6];
  logic signed [COEF_W-1:0] active_reg [6];

  logic [7:0]              y_reg;
  logic signed [8:0]       dcb_reg, dcr_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [7:0]              r_reg, g_reg, b_reg;

  logic                     accept;
  logic [2:0]               coef_idx;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [8:0]        mult_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  sum;
  logic [7:0]               clamp;

  // BT.601 full-range defaults at FRAC=8
  function automatic logic signed [COEF_W-1:0] def_coef(input int idx);
    case (idx)
      1:       def_coef = COEF_W'(359);
      2:       def_coef = COEF_W'(-88);
      3:       def_coef = COEF_W'(-183);
      4:       def_coef = COEF_W'(454);
      default: def_coef = '0;
    endcase
  endfunction

  assign in_ready  = (state_reg == IDLE) || ((state_reg == OUT) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == OUT);
  assign busy_o    = (state_reg != IDLE) && (state_reg != OUT);
  assign r_o       = r_reg;
  assign g_o       = g_reg;
  assign b_o       = b_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    chan_o     = 2'd3;
    case (state_reg)
      IDLE: if (in_valid) state_next = R0;
      R0:   begin state_next = R1;  chan_o = 2'd0; end
      R1:   begin state_next = G0;  chan_o = 2'd0; end
      G0:   begin state_next = G1;  chan_o = 2'd1; end
      G1:   begin state_next = B0;  chan_o = 2'd1; end
      B0:   begin state_next = B1;  chan_o = 2'd2; end
      B1:   begin state_next = OUT; chan_o = 2'd2; end
      OUT:  if (out_ready) state_next = in_valid ? R0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Even index = Cb coefficient (step 0), odd index = Cr coefficient (step 1)
  always_comb begin
    coef_idx = 3'd0;
    mult_b   = dcb_reg;
    case (state_reg)
      R1: begin coef_idx = 3'd1; mult_b = dcr_reg; end
      G0: coef_idx = 3'd2;
      G1: begin coef_idx = 3'd3; mult_b = dcr_reg; end
      B0: coef_idx = 3'd4;
      B1: begin coef_idx = 3'd5; mult_b = dcr_reg; end
      default: ;
    endcase
  end

  assign coef_sel = active_reg[coef_idx];
  assign prod     = coef_sel * mult_b;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign base     = $signed({{COEF_W{1'b0}}, y_reg, {FRAC{1'b0}}}) + ROUND;
  assign sum      = acc_reg + prod_ext;

  always_comb begin
    clamp = sum[FRAC+7:FRAC];
    if (sum[ACC_W-1])               clamp = 8'd0;
    else if (|sum[ACC_W-2:FRAC+8])  clamp = 8'd255;
  end

  // Active bank takes the pre-write shadow value when a write coincides with a handshake
  always_ff @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (!rst_n) begin
        shadow_reg[i] <= def_coef(i);
        active_reg[i] <= def_coef(i);
      end else begin
        if (cfg_we && (cfg_addr == i[2:0])) shadow_reg[i] <= cfg_wdata;
        if (accept)                         active_reg[i] <= shadow_reg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg   <= '0;
      dcb_reg <= '0;
      dcr_reg <= '0;
      acc_reg <= '0;
      r_reg   <= '0;
      g_reg   <= '0;
      b_reg   <= '0;
    end else begin
      if (accept) begin
        y_reg   <= y_i;
        dcb_reg <= $signed({1'b0, cb_i}) - 9'sd128;
        dcr_reg <= $signed({1'b0, cr_i}) - 9'sd128;
      end
      case (state_reg)
        R0, G0, B0: acc_reg <= base + prod_ext;
        R1: begin acc_reg <= sum; r_reg <= clamp; end
        G1: begin acc_reg <= sum; g_reg <= clamp; end
        B1: begin acc_reg <= sum; b_reg <= clamp; end
        default: ;
      endcase
    end
  end

endmodule
